// File: rtl/alarm_pkg.sv
// Shared constants for the alarm code sender and the alarm code detector.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alarm_pkg;

    localparam int SYM_W   = 3;
    localparam int LEN_A   = 4;
    localparam int LEN_B   = 6;
    localparam int MAX_LEN = (LEN_A > LEN_B) ? LEN_A : LEN_B;
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef logic [SYM_W-1:0] sym_t;

    // Entry 0 sits in the least significant slot, so CODE_A[0] is the first symbol sent.
    localparam sym_t [LEN_A-1:0] CODE_A = {3'd0, 3'd0, 3'd7, 3'd1};
    localparam sym_t [LEN_B-1:0] CODE_B = {3'd0, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Y = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/alarm_code_rom.sv
// Code lookup: (selected code, symbol index) -> symbol, plus the length of the selected code.
// Latency: combinational.
// Backpressure: none; out-of-range indices read as symbol 0.
module alarm_code_rom
    import alarm_pkg::*;
(
    input  logic             sel_q,
    input  logic [IDX_W-1:0] idx,
    output logic [SYM_W-1:0] sym,
    output logic [LEN_W-1:0] len
);

    // Compare against every constant index so no variable index can run off either table.
    always_comb begin
        sym = '0;
        if (sel_q) begin
            for (int i = 0; i < LEN_A; i++) begin
                if (idx == IDX_W'(i)) sym = CODE_A[i];
            end
        end else begin
            for (int i = 0; i < LEN_B; i++) begin
                if (idx == IDX_W'(i)) sym = CODE_B[i];
            end
        end
    end

    // Length of the currently selected code.
    always_comb begin
        len = sel_q ? LEN_W'(LEN_A) : LEN_W'(LEN_B);
    end

endmodule

// File: rtl/alarm_code_sender.sv
// Sends a stored alarm code on x, one symbol per HOLD cycles, then reports pass (y seen) or fail (timeout).
// Latency: first symbol one cycle after an accepted start; done pulses one cycle after y or the timeout.
// Backpressure: none; start is accepted only in IDLE and is dropped otherwise (no queueing).
module alarm_code_sender
    import alarm_pkg::*;
#(
    parameter int SYM_W   = alarm_pkg::SYM_W,
    parameter int HOLD    = 1,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic             abort,
    input  logic             y,
    output logic [SYM_W-1:0] x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                     state;
    state_t                     state_nxt;
    logic                       sel_q;
    logic [IDX_W-1:0]           idx;
    logic [HC_W-1:0]            hold_cnt;
    logic [TM_W-1:0]            timer;
    logic [alarm_pkg::SYM_W-1:0] rom_sym;
    logic [LEN_W-1:0]           rom_len;
    logic                       is_last;
    logic                       hold_end;
    logic                       tmo;

    alarm_code_rom u_rom (
        .sel_q (sel_q),
        .idx   (idx),
        .sym   (rom_sym),
        .len   (rom_len)
    );

    assign is_last  = (LEN_W'(idx) == rom_len - LEN_W'(1));
    assign hold_end = (hold_cnt == HC_W'(HOLD - 1));
    assign tmo      = (timer == TM_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: abort outranks everything, and y outranks the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = SEND;
            end
            SEND: begin
                if (abort)                    state_nxt = IDLE;
                else if (is_last && y)        state_nxt = DONE;
                else if (is_last && hold_end) state_nxt = WAIT_Y;
            end
            WAIT_Y: begin
                if (abort)         state_nxt = IDLE;
                else if (y || tmo) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: code latch, symbol index, hold and timeout counters, result flags.
    // Counters stop at their terminal values, so none of them can wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q    <= 1'b0;
            idx      <= '0;
            hold_cnt <= '0;
            timer    <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            idx      <= '0;
            hold_cnt <= '0;
            timer    <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q    <= sel;
                        idx      <= '0;
                        hold_cnt <= '0;
                        timer    <= '0;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                    end
                end
                SEND: begin
                    if (is_last && y) begin
                        pass <= 1'b1;
                    end else if (hold_end) begin
                        hold_cnt <= '0;
                        if (is_last) timer <= '0;
                        else         idx   <= idx + IDX_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                WAIT_Y: begin
                    if (y)        pass  <= 1'b1;
                    else if (tmo) fail  <= 1'b1;
                    else          timer <= timer + TM_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the current state; an abort in DONE suppresses the done pulse.
    always_comb begin
        x       = '0;
        x_valid = 1'b0;
        busy    = (state != IDLE);
        done    = (state == DONE) && !abort;
        if (state == SEND) begin
            x       = SYM_W'(rom_sym);
            x_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_alarm_code_sender.sv
// Bench for alarm_code_sender: two instances (HOLD=1 and HOLD=2) against a cycle-trace reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_alarm_code_sender;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sel, abort;
    logic       st, yv, use2, det_mode, corrupt, ydet;
    logic       start1, start2, y1, y2, ysrc;
    logic [2:0] x1, x2;
    logic       xv1, busy1, done1, pass1, fail1;
    logic       xv2, busy2, done2, pass2, fail2;
    logic [2:0] ox;
    logic       oxv;
    logic [7:0] obs_v;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] obs_tr [64];
    logic [7:0] exp_tr [64];
    bit         ysch [64];
    int         done_at;
    logic [2:0] hist [$];

    assign start1 = st & ~use2;
    assign start2 = st & use2;
    assign ysrc   = det_mode ? ydet : yv;
    assign y1     = ysrc & ~use2;
    assign y2     = ysrc & use2;
    assign ox     = use2 ? x2 : x1;
    assign oxv    = use2 ? xv2 : xv1;
    // observation vector: {busy, x_valid, x[2:0], done, pass, fail}
    assign obs_v  = use2 ? {busy2, xv2, x2, done2, pass2, fail2}
                         : {busy1, xv1, x1, done1, pass1, fail1};

    alarm_code_sender #(.SYM_W(3), .HOLD(1), .TIMEOUT(TMO)) u_h1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sel(sel), .abort(abort), .y(y1),
        .x(x1), .x_valid(xv1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1)
    );

    alarm_code_sender #(.SYM_W(3), .HOLD(2), .TIMEOUT(TMO)) u_h2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sel(sel), .abort(abort), .y(y2),
        .x(x2), .x_valid(xv2), .busy(busy2), .done(done2), .pass(pass2), .fail(fail2)
    );

    // Behavioural alarm detector: pulses y the cycle after the last symbols received match a code.
    function automatic bit det_match();
        int n = hist.size();
        int ca[4] = '{1, 7, 0, 0};
        int cb[6] = '{3, 5, 1, 7, 0, 0};
        bit a = (n >= 4);
        bit b = (n >= 6);
        if (a) for (int i = 0; i < 4; i++) if (int'(hist[n-4+i]) != ca[i]) a = 0;
        if (b) for (int i = 0; i < 6; i++) if (int'(hist[n-6+i]) != cb[i]) b = 0;
        return a | b;
    endfunction

    always @(posedge clk) begin
        if (!det_mode || !oxv) begin
            hist.delete();
            ydet <= 1'b0;
        end else begin
            hist.push_back((corrupt && hist.size() == 2) ? 3'd2 : ox);
            ydet <= det_match();
        end
    end

    function automatic int code_sym(bit s, int i);
        int ca[4] = '{1, 7, 0, 0};
        int cb[6] = '{3, 5, 1, 7, 0, 0};
        return s ? ca[i] : cb[i];
    endfunction

    // Reference model: expected trace from cycle 0 (first cycle after the accepted start).
    // kill_k >= 0 means abort or reset was applied in that cycle.
    task automatic model_seq(input bit s, input int hold, input int kill_k, input int ncyc);
        int L = s ? 4 : 6;
        int S = L * hold;
        int dk = S + TMO;
        bit ps = 0;
        logic [2:0] xs;
        for (int k = (L - 1) * hold; k < S + TMO; k++) begin
            if (ysch[k]) begin
                dk = k + 1;
                ps = 1;
                break;
            end
        end
        done_at = dk;
        for (int k = 0; k < ncyc; k++) begin
            if (kill_k >= 0 && k > kill_k) begin
                exp_tr[k] = 8'b0;
            end else if (k < S && k < dk) begin
                xs = 3'(code_sym(s, k / hold));
                exp_tr[k] = {1'b1, 1'b1, xs, 3'b000};
            end else if (k < dk) begin
                exp_tr[k] = 8'b1000_0000;
            end else if (k == dk) begin
                exp_tr[k] = {1'b1, 1'b0, 3'b000, 1'b1, ps, ~ps};
            end else begin
                exp_tr[k] = {6'b0, ps, ~ps};
            end
        end
    endtask

    task automatic clr_ysch();
        for (int k = 0; k < 64; k++) ysch[k] = 0;
    endtask

    // Starts one operation and records the observed trace; sel is scrambled after the start edge.
    task automatic run_seq(input bit h2, input bit s, input int st_until, input int ab_k,
                           input int rst_k, input int ncyc);
        @(negedge clk);
        use2 = h2; sel = s; st = 1; abort = 0; yv = 0;
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            obs_tr[k] = obs_v;
            sel   = 1'($urandom);
            st    = (k < st_until);
            yv    = ysch[k];
            abort = (k == ab_k);
            rst_n = !(k == rst_k);
            @(posedge clk);
        end
        @(negedge clk);
        st = 0; yv = 0; abort = 0; rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; st = 0; yv = 0; abort = 0; sel = 0; use2 = 0; det_mode = 0; corrupt = 0;
        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            use2 = 1'(d);
            #1;
            vectors++;
            if (obs_v !== 8'b0) begin
                miscompares++;
                $display("FAIL reset dut%0d got %b want %b", d + 1, obs_v, 8'b0);
            end
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_code_a();
        clr_ysch();
        ysch[4] = 1;
        model_seq(1, 1, -1, 8);
        run_seq(0, 1, 0, -1, -1, 8);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs_tr[k] !== exp_tr[k]) begin
                miscompares++;
                $display("FAIL code_a k=%0d got %b want %b", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_code_b_timeout();
        int first_done = -1;
        clr_ysch();
        model_seq(0, 2, -1, 23);
        run_seq(1, 0, 0, -1, -1, 23);
        for (int k = 0; k < 23; k++) begin
            vectors++;
            if (obs_tr[k] !== exp_tr[k]) begin
                miscompares++;
                $display("FAIL code_b_timeout k=%0d got %b want %b", k, obs_tr[k], exp_tr[k]);
            end
            if (first_done < 0 && obs_tr[k][2]) first_done = k;
        end
        vectors++;
        if (first_done !== 12 + TMO) begin
            miscompares++;
            $display("FAIL timeout_distance done at %0d want %0d", first_done, 12 + TMO);
        end
    endtask

    task automatic test_abort();
        bit s = 1'($urandom);
        clr_ysch();
        model_seq(s, 1, 2, 15);
        run_seq(0, s, 0, 2, -1, 15);
        for (int k = 0; k < 15; k++) begin
            vectors++;
            if (obs_tr[k] !== exp_tr[k]) begin
                miscompares++;
                $display("FAIL abort k=%0d got %b want %b", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clr_ysch();
        ysch[4] = 1;
        model_seq(1, 1, -1, 10);
        run_seq(0, 1, done_at + 1, -1, -1, 10);
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (obs_tr[k] !== exp_tr[k]) begin
                miscompares++;
                $display("FAIL held_start k=%0d got %b want %b", k, obs_tr[k], exp_tr[k]);
            end
        end
        clr_ysch();
        model_seq(0, 1, -1, 18);
        run_seq(0, 0, 0, -1, -1, 18);
        for (int k = 0; k < 18; k++) begin
            vectors++;
            if (obs_tr[k] !== exp_tr[k]) begin
                miscompares++;
                $display("FAIL restart k=%0d got %b want %b", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clr_ysch();
        ysch[10] = 1;
        model_seq(1, 2, 10, 14);
        run_seq(1, 1, 0, -1, 10, 14);
        for (int k = 0; k < 14; k++) begin
            vectors++;
            if (obs_tr[k] !== exp_tr[k]) begin
                miscompares++;
                $display("FAIL reset_mid k=%0d got %b want %b", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_closed_loop();
        for (int c = 0; c < 3; c++) begin
            bit s = (c == 0);
            det_mode = 1;
            corrupt  = (c == 2);
            clr_ysch();
            if (!corrupt) ysch[s ? 4 : 6] = 1;
            model_seq(s, 1, -1, 18);
            run_seq(0, s, 0, -1, -1, 18);
            for (int k = 0; k < 18; k++) begin
                vectors++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    miscompares++;
                    $display("FAIL closed_loop case=%0d k=%0d got %b want %b", c, k, obs_tr[k], exp_tr[k]);
                end
            end
        end
        det_mode = 0;
        corrupt  = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            bit h2 = 1'($urandom);
            bit s  = 1'($urandom);
            int hold = h2 ? 2 : 1;
            int ab_k = -1;
            int m = 3;
            int stu;
            int ncyc;
            clr_ysch();
            for (int k = 0; k < 40; k++) ysch[k] = ($urandom_range(0, 9) == 0);
            model_seq(s, hold, -1, 1);
            if ($urandom_range(0, 3) == 0) ab_k = $urandom_range(0, done_at - 1);
            if (ab_k >= 0 && ab_k + 1 < m) m = ab_k + 1;
            stu  = $urandom_range(0, m);
            ncyc = done_at + 3;
            model_seq(s, hold, ab_k, ncyc);
            run_seq(h2, s, stu, ab_k, -1, ncyc);
            for (int k = 0; k < ncyc; k++) begin
                vectors++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    miscompares++;
                    $display("FAIL random it=%0d k=%0d got %b want %b", it, k, obs_tr[k], exp_tr[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_code_a();
        test_code_b_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_closed_loop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
